sram_a_arb: RTL and testbench

Two-port round-robin arbiter and sequencer for the `sram_A` activation buffer (1024 x 8, single port, registered read). Shares the one SRAM port between the host loader (port 0) and the compute engine (port 1). Registers all SRAM control signals and returns tagged read data with a fixed latency. Sits directly in front of `sram_A` in the `rpll_clk` domain.

---
 rtl/sram_a_arb.sv | 142 ++++++++++++++
 tb/tb_sram_a_arb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_a_arb.sv
// sram_a_arb: two-port arbiter and sequencer in front of the sram_A activation buffer.
// Port 0 is the host loader, port 1 the compute engine. All SRAM controls are registered
// and read data comes back tagged with the owning port after a fixed latency.
// Build option: define SRAM_A_ARB_RR_EN for round-robin arbitration; when it is left
// undefined, port 0 has fixed priority and no arbitration state is kept.
module sram_a_arb #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          rpll_clk,
  input  logic          rst,
  // port 0: host loader
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  // port 1: compute engine
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  // sram_A port
  output logic          sram_A_we,
  output logic [AW-1:0] sram_A_addr,
  output logic [DW-1:0] sram_A_din,
  input  logic [DW-1:0] sram_A_dout
);

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any_gnt;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_rd_push;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;

  // Read tag pipeline: stage 0 lines up with the registered SRAM address, the tail with
  // the SRAM read data.
  logic [RD_LAT:0] r_rd_vld;
  logic [RD_LAT:0] r_rd_port;

`ifdef SRAM_A_ARB_RR_EN
  // 1 = port 1 was granted last; reset value lets port 0 win the first contention.
  logic r_last;

  // Round-robin grant: a lone requester wins, on contention the port not granted last wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = p0_req;
        w_gnt1 = p1_req;
      end
    end
  end

  // Track the last granted port; untouched in idle cycles.
  always_ff @(posedge rpll_clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end
  end
`else
  // Fixed-priority grant: port 1 only when port 0 is not requesting.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      w_gnt0 = p0_req;
      w_gnt1 = p1_req & ~p0_req;
    end
  end
`endif

  // Select the fields of the granted port; a read grant pushes a tag into the pipeline.
  always_comb begin
    w_any_gnt   = w_gnt0 | w_gnt1;
    w_sel_we    = w_gnt1 ? p1_we    : p0_we;
    w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
    w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;
    w_rd_push   = w_any_gnt & ~w_sel_we;
  end

  // SRAM control registers: load on grant, otherwise drop we and hold address/data.
  always_ff @(posedge rpll_clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_any_gnt) begin
      r_we   <= w_sel_we;
      r_addr <= w_sel_addr;
      r_din  <= w_sel_wdata;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Shift read tags towards the tail; reset discards everything in flight.
  always_ff @(posedge rpll_clk or posedge rst) begin
    if (rst) begin
      r_rd_vld  <= '0;
      r_rd_port <= '0;
    end else begin
      r_rd_vld  <= {r_rd_vld[RD_LAT-1:0], w_rd_push};
      r_rd_port <= {r_rd_port[RD_LAT-1:0], w_gnt1};
    end
  end

  // Drive grants, SRAM controls and per-port read returns.
  always_comb begin
    p0_gnt      = w_gnt0;
    p1_gnt      = w_gnt1;
    sram_A_we   = r_we;
    sram_A_addr = r_addr;
    sram_A_din  = r_din;
    p0_rvalid   = r_rd_vld[RD_LAT] & ~r_rd_port[RD_LAT];
    p1_rvalid   = r_rd_vld[RD_LAT] &  r_rd_port[RD_LAT];
    p0_rdata    = sram_A_dout;
    p1_rdata    = sram_A_dout;
  end

endmodule

// File: tb/tb_sram_a_arb.sv
// Bench for sram_a_arb: a behavioural model (reference memory, grant rule, queue of expected
// read returns) is compared with the DUT every cycle, plus directed literal checks. A second
// instance with RD_LAT = 3 checks the longer return latency.
module tb_sram_a_arb;

  localparam int unsigned LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [9:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       sram_A_we;
  logic [9:0] sram_A_addr;
  logic [7:0] sram_A_din, sram_A_dout;

  always #5 clk = ~clk;

  sram_a_arb #(.AW(10), .DW(8), .RD_LAT(LAT)) u_dut (
    .rpll_clk   (clk),
    .rst        (rst),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_gnt     (p0_gnt),
    .p0_rvalid  (p0_rvalid),
    .p0_rdata   (p0_rdata),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_gnt     (p1_gnt),
    .p1_rvalid  (p1_rvalid),
    .p1_rdata   (p1_rdata),
    .sram_A_we  (sram_A_we),
    .sram_A_addr(sram_A_addr),
    .sram_A_din (sram_A_din),
    .sram_A_dout(sram_A_dout)
  );

  // Second instance, RD_LAT = 3
  logic       rst_3;
  logic       p0_req_3, p0_we_3, p1_req_3, p1_we_3;
  logic [9:0] p0_addr_3, p1_addr_3;
  logic [7:0] p0_wdata_3, p1_wdata_3;
  logic       p0_gnt_3, p1_gnt_3, p0_rvalid_3, p1_rvalid_3;
  logic [7:0] p0_rdata_3, p1_rdata_3;
  logic       sram_we_3;
  logic [9:0] sram_addr_3;
  logic [7:0] sram_din_3, sram_dout_3;

  sram_a_arb #(.AW(10), .DW(8), .RD_LAT(3)) u_dut3 (
    .rpll_clk   (clk),
    .rst        (rst_3),
    .p0_req     (p0_req_3),
    .p0_we      (p0_we_3),
    .p0_addr    (p0_addr_3),
    .p0_wdata   (p0_wdata_3),
    .p0_gnt     (p0_gnt_3),
    .p0_rvalid  (p0_rvalid_3),
    .p0_rdata   (p0_rdata_3),
    .p1_req     (p1_req_3),
    .p1_we      (p1_we_3),
    .p1_addr    (p1_addr_3),
    .p1_wdata   (p1_wdata_3),
    .p1_gnt     (p1_gnt_3),
    .p1_rvalid  (p1_rvalid_3),
    .p1_rdata   (p1_rdata_3),
    .sram_A_we  (sram_we_3),
    .sram_A_addr(sram_addr_3),
    .sram_A_din (sram_din_3),
    .sram_A_dout(sram_dout_3)
  );

  // SRAM models: single port, registered read with the instance's latency.
  logic [7:0] mem1 [1024];
  logic [7:0] rdp1;
  logic [7:0] mem3 [1024];
  logic [7:0] rdp3 [3];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (sram_A_we) mem1[sram_A_addr] <= sram_A_din;
    rdp1 <= mem1[sram_A_addr];
  end
  assign sram_A_dout = rdp1;

  always @(posedge clk) begin
    if (sram_we_3) mem3[sram_addr_3] <= sram_din_3;
    rdp3[0] <= mem3[sram_addr_3];
    rdp3[1] <= rdp3[0];
    rdp3[2] <= rdp3[1];
  end
  assign sram_dout_3 = rdp3[2];

  // Counters and check helper
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model state
  logic [7:0] refmem [1024];
  logic       exp_we;
  logic [9:0] exp_addr;
  logic [7:0] exp_din;
  int         q_port [$];
  int         q_due  [$];
  logic [7:0] q_data [$];
  logic       e0, e1, ev0, ev1;
  logic [7:0] ed;
`ifdef SRAM_A_ARB_RR_EN
  int         m_last = 1;
`endif

  initial begin
    for (int i = 0; i < 1024; i++) refmem[i] = 8'h00;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_sram_we", sram_A_we, 0);
      chk("rst_sram_addr", sram_A_addr, 0);
      chk("rst_sram_din", sram_A_din, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_din  = '0;
      q_port.delete();
      q_due.delete();
      q_data.delete();
`ifdef SRAM_A_ARB_RR_EN
      m_last = 1;
`endif
    end else begin
      if (p0_req && p1_req) begin
`ifdef SRAM_A_ARB_RR_EN
        e0 = (m_last == 1);
        e1 = (m_last == 0);
`else
        e0 = 1'b1;
        e1 = 1'b0;
`endif
      end else begin
        e0 = p0_req;
        e1 = p1_req;
      end
      chk("p0_gnt", p0_gnt, e0);
      chk("p1_gnt", p1_gnt, e1);
      chk("sram_we", sram_A_we, exp_we);
      chk("sram_addr", sram_A_addr, exp_addr);
      chk("sram_din", sram_A_din, exp_din);
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = 8'h00;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        ed = q_data[0];
        if (q_port[0] == 0) ev0 = 1'b1;
        else                ev1 = 1'b1;
        void'(q_port.pop_front());
        void'(q_due.pop_front());
        void'(q_data.pop_front());
      end
      chk("p0_rvalid", p0_rvalid, ev0);
      chk("p1_rvalid", p1_rvalid, ev1);
      if (ev0) chk("p0_rdata", p0_rdata, ed);
      if (ev1) chk("p1_rdata", p1_rdata, ed);
      // The write shown this cycle lands in the SRAM at the coming edge.
      if (exp_we) refmem[exp_addr] = exp_din;
      exp_we = 1'b0;
      if (e0 || e1) begin
        exp_we   = e1 ? p1_we    : p0_we;
        exp_addr = e1 ? p1_addr  : p0_addr;
        exp_din  = e1 ? p1_wdata : p0_wdata;
        if (!exp_we) begin
          q_port.push_back(e1 ? 1 : 0);
          q_due.push_back(cyc + 1 + LAT);
          q_data.push_back(refmem[exp_addr]);
        end
`ifdef SRAM_A_ARB_RR_EN
        m_last = e1 ? 1 : 0;
`endif
      end
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int p, input logic req, input logic we, input logic [9:0] a,
                       input logic [7:0] d);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic rnd_port(input int p);
    logic [9:0] a;
    a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
    set_p(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  logic done3 = 1'b0;

  // RD_LAT = 3 instance: write then read, read data returns 4 cycles after grant.
  initial begin
    rst_3 = 1'b1;
    p0_req_3 = 0; p0_we_3 = 0; p0_addr_3 = '0; p0_wdata_3 = '0;
    p1_req_3 = 0; p1_we_3 = 0; p1_addr_3 = '0; p1_wdata_3 = '0;
    repeat (3) tick();
    rst_3 = 1'b0;
    p0_req_3 = 1; p0_we_3 = 1; p0_addr_3 = 10'h3FF; p0_wdata_3 = 8'hA5;
    @(negedge clk);
    chk("l3_p0_gnt", p0_gnt_3, 1);
    tick();
    p0_req_3 = 0;
    chk("l3_sram_we", sram_we_3, 1);
    chk("l3_sram_addr", sram_addr_3, 10'h3FF);
    chk("l3_sram_din", sram_din_3, 8'hA5);
    p1_req_3 = 1; p1_we_3 = 0; p1_addr_3 = 10'h3FF;
    @(negedge clk);
    chk("l3_p1_gnt", p1_gnt_3, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      p1_req_3 = 0;
      chk("l3_p1_rvalid", p1_rvalid_3, (k == 4) ? 1 : 0);
      if (k == 4) chk("l3_p1_rdata", p1_rdata_3, 8'hA5);
    end
    done3 = 1'b1;
  end

  logic [6:0] g0v, g1v;
  logic [8:0] rv0v, rv1v;
  logic       g0, g1;
  int         n_ops, guard;

  initial begin
    rst = 1'b1;
    set_p(0, 0, 0, '0, '0);
    set_p(1, 0, 0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;

    // Port-0 write of A5 to 3FF, then port-1 read returns it two cycles after grant.
    set_p(0, 1, 1, 10'h3FF, 8'hA5);
    @(negedge clk);
    chk("t1_p0_gnt", p0_gnt, 1);
    chk("t1_p1_gnt", p1_gnt, 0);
    tick();
    set_p(0, 0, 0, '0, '0);
    chk("t1_sram_we", sram_A_we, 1);
    chk("t1_sram_addr", sram_A_addr, 10'h3FF);
    chk("t1_sram_din", sram_A_din, 8'hA5);
    set_p(1, 1, 0, 10'h3FF, '0);
    @(negedge clk);
    chk("t1_p1_gnt_rd", p1_gnt, 1);
    tick();
    set_p(1, 0, 0, '0, '0);
    chk("t1_rvalid_early", p1_rvalid, 0);
    tick();
    chk("t1_p1_rvalid", p1_rvalid, 1);
    chk("t1_p1_rdata", p1_rdata, 8'hA5);
    chk("t1_p0_rvalid", p0_rvalid, 0);
    tick();
    chk("t1_rvalid_after", p1_rvalid, 0);

    // Both ports read from the first cycle after reset; port 0 drops first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_p(0, i < 6, 0, 10'h3FF, '0);
      set_p(1, i < 7, 0, 10'h010, '0);
      @(negedge clk);
      if (i < 7) begin
        g0v[i] = p0_gnt;
        g1v[i] = p1_gnt;
      end
      rv0v[i] = p0_rvalid;
      rv1v[i] = p1_rvalid;
      tick();
    end
    set_p(1, 0, 0, '0, '0);
`ifdef SRAM_A_ARB_RR_EN
    chk("t2_p0_gnt_seq", g0v, 7'b0010101);
    chk("t2_p1_gnt_seq", g1v, 7'b1101010);
    chk("t2_p0_rvalid_seq", rv0v, 9'b001010100);
    chk("t2_p1_rvalid_seq", rv1v, 9'b110101000);
`else
    chk("t2_p0_gnt_seq", g0v, 7'b0111111);
    chk("t2_p1_gnt_seq", g1v, 7'b1000000);
    chk("t2_p0_rvalid_seq", rv0v, 9'b011111100);
    chk("t2_p1_rvalid_seq", rv1v, 9'b100000000);
`endif

    // Port 1 write then read of the same address on consecutive grants.
    set_p(1, 1, 1, 10'h010, 8'h11);
    @(negedge clk);
    chk("t3_p1_gnt_wr", p1_gnt, 1);
    tick();
    set_p(1, 1, 0, 10'h010, '0);
    @(negedge clk);
    chk("t3_p1_gnt_rd", p1_gnt, 1);
    tick();
    set_p(1, 0, 0, '0, '0);
    tick();
    chk("t3_p1_rvalid", p1_rvalid, 1);
    chk("t3_p1_rdata", p1_rdata, 8'h11);

    // Reset while two reads are in flight: no returns afterwards.
    set_p(0, 1, 0, 10'h3FF, '0);
    tick();
    set_p(0, 1, 0, 10'h010, '0);
    tick();
    set_p(0, 0, 0, '0, '0);
    rst = 1'b1;
    #1;
    chk("t4_p0_rvalid_rst", p0_rvalid, 0);
    chk("t4_p1_rvalid_rst", p1_rvalid, 0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_p0_rvalid", p0_rvalid, 0);
      chk("t4_no_p1_rvalid", p1_rvalid, 0);
      tick();
    end

    // Reset drops a registered write; port 0 wins the next contention.
    set_p(0, 1, 1, 10'h010, 8'h5A);
    tick();
    set_p(0, 0, 0, '0, '0);
    chk("t5_sram_we_pend", sram_A_we, 1);
    rst = 1'b1;
    #1;
    chk("t5_sram_we_rst", sram_A_we, 0);
    tick();
    rst = 1'b0;
    set_p(0, 1, 0, 10'h010, '0);
    set_p(1, 1, 0, 10'h3FF, '0);
    @(negedge clk);
    chk("t5_p0_wins", p0_gnt, 1);
    chk("t5_p1_waits", p1_gnt, 0);
    tick();
    set_p(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t5_p1_gnt", p1_gnt, 1);
    tick();
    set_p(1, 0, 0, '0, '0);
    chk("t5_p0_rvalid", p0_rvalid, 1);
    chk("t5_p0_rdata_old", p0_rdata, 8'h11);
    tick();
    chk("t5_p1_rvalid", p1_rvalid, 1);
    chk("t5_p1_rdata", p1_rdata, 8'hA5);

    // Random mixed traffic, requests held until granted.
    n_ops = 0;
    guard = 0;
    rnd_port(0);
    rnd_port(1);
    while (n_ops < 1000 && guard < 20000) begin
      @(negedge clk);
      g0 = p0_gnt;
      g1 = p1_gnt;
      n_ops += int'(g0) + int'(g1);
      guard++;
      tick();
      if (!p0_req || g0) rnd_port(0);
      if (!p1_req || g1) rnd_port(1);
    end
    chk("rand_ops_done", n_ops >= 1000, 1);
    set_p(0, 0, 0, '0, '0);
    set_p(1, 0, 0, '0, '0);
    repeat (LAT + 3) tick();
    chk("rand_queue_drained", q_due.size(), 0);

    guard = 0;
    while (!done3 && guard < 100) begin
      tick();
      guard++;
    end
    chk("lat3_done", done3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
